// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode encodings and select-width helper for the stream mux.
package stream_mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: N producer channels in, one registered stream out, plus mode/select.
interface stream_mux_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = stream_mux_pkg::clog2_min1(NUM_CH)
);
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick of the first requester after ptr (rotate, priority-encode, un-rotate).
module rr_pick import stream_mux_pkg::*; #(
    parameter int NUM_CH = 4,
    localparam int SEL_W = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);
    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [SEL_W-1:0]    start, enc;
    logic [SEL_W:0]      sum;
    always_comb begin
        start = (ptr >= SEL_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
        dbl = {req, req};
        rot = dbl[start +: NUM_CH];
        enc = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) if (rot[i]) enc = SEL_W'(i);
        // channel counts need not be powers of two, so wrap explicitly
        sum = {1'b0, enc} + {1'b0, start};
        gnt_idx = (sum >= (SEL_W+1)'(NUM_CH)) ? SEL_W'(sum - (SEL_W+1)'(NUM_CH)) : sum[SEL_W-1:0];
        gnt_any = |req;
    end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream mux with registered output,
// fixed-select or round-robin arbitration.
module stream_mux_rr import stream_mux_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = clog2_min1(NUM_CH);
    logic [SEL_W-1:0] ptr, rr_idx, grant;
    logic             rr_any, has_grant, load_en, xfer;
    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req(bus.in_valid), .ptr(ptr), .gnt_idx(rr_idx), .gnt_any(rr_any)
    );
    always_comb begin
        load_en = !bus.out_valid || bus.out_ready;
        grant = (bus.mode == MODE_FIXED) ? bus.sel : rr_idx;
        has_grant = (bus.mode == MODE_FIXED) ? ({1'b0, bus.sel} < (SEL_W+1)'(NUM_CH)) : rr_any;
        // rst_n gating keeps in_ready low while the output register is held in reset
        bus.in_ready = (has_grant && load_en && rst_n) ? (NUM_CH'(1) << grant) : '0;
        xfer = |(bus.in_valid & bus.in_ready);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[grant*DATA_W +: DATA_W];
            bus.out_ch    <= grant;
            if (bus.mode == MODE_RR) ptr <= grant;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed table-driven checks of stream_mux_rr (4 channels) plus a 6-channel build.
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.NUM_CH(4), .DATA_W(8)) b4 ();
    stream_mux_rr_if #(.NUM_CH(6), .DATA_W(8)) b6 ();
    stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    stream_mux_rr #(.NUM_CH(6), .DATA_W(8)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    typedef struct {
        logic        m;
        logic [1:0]  sel;
        logic [3:0]  v;
        logic [31:0] d;
        logic        ordy;
        logic [3:0]  ir;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  ch;
    } vec_t;
    vec_t tbl[$];

    localparam logic [31:0] DA = 32'hD3C2B1A0;
    localparam logic [31:0] DX = 32'hD3A5B1A0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        b4.mode = 1'b1; b4.sel = '0; b4.in_valid = 4'hF; b4.in_data = DA; b4.out_ready = 1'b1;
        b6.mode = 1'b0; b6.sel = '0; b6.in_valid = '0; b6.in_data = '0; b6.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 48'(b4.out_valid), 48'h0);
        chk("rst out_data", 48'(b4.out_data), 48'h0);
        chk("rst out_ch", 48'(b4.out_ch), 48'h0);
        chk("rst in_ready", 48'(b4.in_ready), 48'h0);
        b4.in_valid = '0;
        rst_n = 1'b1;

        // six-channel build: top index, out-of-range selects, RR wrap at ptr=5
        b6.sel = 3'd5; b6.in_valid = 6'b100000; b6.in_data = 48'h5E00_0000_0011;
        #1 chk("n6 sel5 in_ready", 48'(b6.in_ready), 48'h20);
        @(posedge clk); #1;
        chk("n6 sel5 out_data", 48'(b6.out_data), 48'h5E);
        chk("n6 sel5 out_ch", 48'(b6.out_ch), 48'h5);
        chk("n6 sel5 out_valid", 48'(b6.out_valid), 48'h1);
        b6.sel = 3'd6; b6.in_valid = 6'h3F;
        #1 chk("n6 sel6 in_ready", 48'(b6.in_ready), 48'h0);
        @(posedge clk); #1;
        chk("n6 sel6 out_valid", 48'(b6.out_valid), 48'h0);
        chk("n6 sel6 out_data", 48'(b6.out_data), 48'h5E);
        b6.sel = 3'd7;
        #1 chk("n6 sel7 in_ready", 48'(b6.in_ready), 48'h0);
        @(posedge clk); #1;
        chk("n6 sel7 out_valid", 48'(b6.out_valid), 48'h0);
        b6.mode = 1'b1; b6.in_valid = 6'b100001;
        #1 chk("n6 rr0 in_ready", 48'(b6.in_ready), 48'h01);
        @(posedge clk); #1;
        chk("n6 rr0 out_ch", 48'(b6.out_ch), 48'h0);
        #1 chk("n6 rr1 in_ready", 48'(b6.in_ready), 48'h20);
        @(posedge clk); #1;
        chk("n6 rr1 out_ch", 48'(b6.out_ch), 48'h5);
        b6.in_valid = '0;

        for (int k = 0; k < 2; k++) begin
            tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0});
            tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1});
            tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2});
            tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3});
        end
        for (int k = 0; k < 2; k++) begin
            tbl.push_back('{1'b1, 2'd0, 4'hA, DA, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1});
            tbl.push_back('{1'b1, 2'd0, 4'hA, DA, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3});
        end
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1});
        tbl.push_back('{1'b0, 2'd0, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0});
        tbl.push_back('{1'b0, 2'd0, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2});
        tbl.push_back('{1'b0, 2'd3, 4'h7, DA, 1'b1, 4'b1000, 1'b0, 8'hC2, 2'd2});
        tbl.push_back('{1'b0, 2'd2, 4'h4, DX, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2});
        tbl.push_back('{1'b0, 2'd2, 4'h0, DX, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2});
        tbl.push_back('{1'b0, 2'd2, 4'h0, DX, 1'b1, 4'b0100, 1'b0, 8'hA5, 2'd2});
        tbl.push_back('{1'b1, 2'd0, 4'h0, DA, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2});

        foreach (tbl[i]) begin
            b4.mode = tbl[i].m; b4.sel = tbl[i].sel; b4.in_valid = tbl[i].v;
            b4.in_data = tbl[i].d; b4.out_ready = tbl[i].ordy;
            #1 chk($sformatf("v%0d in_ready", i), 48'(b4.in_ready), 48'(tbl[i].ir));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 48'(b4.out_valid), 48'(tbl[i].ov));
            chk($sformatf("v%0d out_data", i), 48'(b4.out_data), 48'(tbl[i].od));
            chk($sformatf("v%0d out_ch", i), 48'(b4.out_ch), 48'(tbl[i].ch));
        end

        // async reset while a word is held under backpressure (ptr is 2 here)
        b4.mode = 1'b1; b4.in_valid = 4'hF; b4.in_data = DA; b4.out_ready = 1'b0;
        #1 chk("ar pre in_ready", 48'(b4.in_ready), 48'h8);
        @(posedge clk); #1;
        chk("ar held out_valid", 48'(b4.out_valid), 48'h1);
        chk("ar held out_ch", 48'(b4.out_ch), 48'h3);
        #1 rst_n = 1'b0;
        #1;
        chk("ar async out_valid", 48'(b4.out_valid), 48'h0);
        chk("ar async out_data", 48'(b4.out_data), 48'h0);
        chk("ar async in_ready", 48'(b4.in_ready), 48'h0);
        #1 rst_n = 1'b1; b4.out_ready = 1'b1;
        #1 chk("ar post in_ready", 48'(b4.in_ready), 48'h1);
        @(posedge clk); #1;
        chk("ar post out_ch", 48'(b4.out_ch), 48'h0);
        chk("ar post out_data", 48'(b4.out_data), 48'hA0);
        chk("ar post out_valid", 48'(b4.out_valid), 48'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
